seq_mult16: RTL

- Sequential unsigned 16x16 -> 32-bit shift-and-add multiplier.
- Sequences one FA16 ripple adder across 16 iterations instead of instantiating an array multiplier.
- Sits beside the FA4/FA16 adder hierarchy as its first multi-cycle consumer.
- Start/Busy/Done handshake toward the requesting logic.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/FA16.sv | 21 ++
 rtl/seq_mult16.sv | 100 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: state encoding and
// iteration constants tied to the FA16 adder width.
package mult_pkg;

    localparam int WIDTH     = 16;
    localparam int CNT_W     = 5;
    localparam int LAST_ITER = WIDTH - 1;

    // 2'd3 is never entered intentionally; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_accepting(input state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/FA16.sv
// 16-bit ripple-carry adder built from a chain of single-bit full-adder cells.
module FA16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        CIn,
    output logic [15:0] S,
    output logic        COut
);

    logic [16:0] carry;

    assign carry[0] = CIn;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign S[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign COut = carry[16];

endmodule

// File: rtl/seq_mult16.sv
// Sequential unsigned 16x16 shift-and-add multiplier reusing one FA16 over
// sixteen iterations, with a Start/Busy/Done handshake and a held product.
module seq_mult16
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] P
);

    if (WIDTH != 16 || (2 ** CNT_W) <= WIDTH) begin : g_bad_params
        $error("seq_mult16: WIDTH must be 16 and 2**CNT_W must exceed WIDTH");
    end

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry_out;
    logic [2*WIDTH-1:0] next_acc_q;

    assign addend = q[0] ? m : '0;

    FA16 u_adder (
        .A    (acc),
        .B    (addend),
        .CIn  (1'b0),
        .S    (sum),
        .COut (carry_out)
    );

    // The adder carry becomes the new ACC MSB after the right shift; losing it
    // corrupts products whose partial sums overflow 16 bits.
    assign next_acc_q = {carry_out, sum, q[WIDTH-1:1]};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            cnt   <= '0;
            P     <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        m     <= A;
                        q     <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    {acc, q} <= next_acc_q;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CNT_W'(LAST_ITER)) begin
                        P     <= next_acc_q;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake invariants: outputs are mutually exclusive and Done is a pulse.
    assert property (@(posedge Clk) disable iff (Rst) !(Busy && Done));
    assert property (@(posedge Clk) disable iff (Rst) Done |=> !Done);
    assert property (@(posedge Clk) disable iff (Rst) Busy == (state == RUN));
    assert property (@(posedge Clk) disable iff (Rst) Done == (state == DONE));
    assert property (@(posedge Clk) disable iff (Rst)
                     is_accepting(state) |-> !Busy);

endmodule
